// File: rtl/demux4_buf_pkg.sv
// Shared types and constants for the 4-port buffered demultiplexer.
// Imported by demux4_buf and its per-port FIFO slot.
package demux4_buf_pkg;

  localparam int unsigned NUM_PORTS  = 4;
  localparam int unsigned FIFO_DEPTH = 2;

  typedef logic [1:0] sel_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

endpackage

// File: rtl/fifo2_slot.sv
// Two-entry FIFO owned by one output port of demux4_buf.
// Exposes its occupancy so the router can derive valid/full itself.
module fifo2_slot
  import demux4_buf_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output occ_t             occ_o
);

  logic [FIFO_DEPTH-1:0][WIDTH-1:0] mem_q;
  logic                             wr_ptr_q, wr_ptr_d;
  logic                             rd_ptr_q, rd_ptr_d;
  occ_t                             occ_q, occ_d;
  logic                             push, pop;

  // A full slot never takes a push, even if it is popped this cycle.
  assign push = push_i && (occ_q != FULL);
  assign pop  = pop_i && (occ_q != EMPTY);

  always_comb begin
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    case (occ_q)
      EMPTY: if (push) occ_d = ONE;
      ONE: begin
        if (push && !pop)      occ_d = FULL;
        else if (pop && !push) occ_d = EMPTY;
      end
      FULL:    if (pop) occ_d = ONE;
      default: occ_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q    <= EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign head_o = (occ_q != EMPTY) ? mem_q[rd_ptr_q] : '0;
  assign occ_o  = occ_q;

endmodule

// File: rtl/demux4_buf.sv
// Routes one input stream to four independently buffered output ports.
// in_ready depends only on the selected slot's occupancy, never on out_ready.
module demux4_buf
  import demux4_buf_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                in_data,
  input  sel_t                            in_sel,
  output logic [NUM_PORTS-1:0]            out_valid,
  input  logic [NUM_PORTS-1:0]            out_ready,
  output logic [NUM_PORTS-1:0][WIDTH-1:0] out_data,
  output logic                            busy
);

  logic [NUM_PORTS-1:0]            push, pop;
  logic [NUM_PORTS-1:0][WIDTH-1:0] slot_head;
  occ_t                            slot_occ [NUM_PORTS];

  assign in_ready = rst_n && (slot_occ[in_sel] != FULL);
  assign busy     = |out_valid;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign push[g] = in_valid && in_ready && (in_sel == sel_t'(g));
    assign pop[g]  = out_valid[g] && out_ready[g];

    // Outputs are masked while reset is held, since the slots clear only on the edge.
    assign out_valid[g] = rst_n && (slot_occ[g] != EMPTY);
    assign out_data[g]  = rst_n ? slot_head[g] : '0;

    fifo2_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .push_i(push[g]),
      .data_i(in_data),
      .pop_i (pop[g]),
      .head_o(slot_head[g]),
      .occ_o (slot_occ[g])
    );
  end

endmodule
